// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Shared by both builds; MDU_SIGNED_EN only affects mul_div_unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      MUL   = 2'b00,
      MULHU = 2'b01,
      DIVU  = 2'b10,
      REMU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } mdu_state_e;

   localparam int MDU_DASIZE = 32;

   // Quotient returned for a zero divisor; sliced down to the datapath width.
   localparam logic [63:0] DIV0_QUO = '1;

   localparam int MDU_CNT_W = $clog2(MDU_DASIZE) + 1;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide feeding the RegFile write port.
// Define MDU_SIGNED_EN to add the 'sign' input and signed MUL/MULH/DIV/REM.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int DASize = 32,
   parameter int ADSize = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
`ifdef MDU_SIGNED_EN
   input  logic              sign,
`endif
   input  logic [DASize-1:0] OP_1,
   input  logic [DASize-1:0] OP_2,
   input  logic [ADSize-1:0] Dest_ADDR,
   output logic              busy,
   output logic              done,
   output logic [DASize-1:0] RESULT,
   output logic              Write,
   output logic [ADSize-1:0] Write_ADDR
);

   localparam int CW = cnt_width(DASize);
   localparam int W2 = 2 * DASize;

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [DASize-1:0] mcand_q, mcand_d;
   logic [W2-1:0]     prod_q, prod_d;
   logic [DASize-1:0] result_q, result_d;
   logic [ADSize-1:0] waddr_q, waddr_d;

   // Request decode: signed ops work on magnitudes and fix the sign at the end.
   logic              sgn_req;
   logic              a_neg, b_neg, neg_in;
   logic [DASize-1:0] a_mag, b_mag;
   mdu_op_e           op_in;
   logic              div0_in;

`ifdef MDU_SIGNED_EN
   assign sgn_req = sign;
`else
   assign sgn_req = 1'b0;
`endif

   assign op_in   = mdu_op_e'(op);
   assign a_neg   = sgn_req & OP_1[DASize-1];
   assign b_neg   = sgn_req & OP_2[DASize-1];
   assign a_mag   = a_neg ? -OP_1 : OP_1;
   assign b_mag   = b_neg ? -OP_2 : OP_2;
   assign neg_in  = (op_in == REMU) ? a_neg : (a_neg ^ b_neg);
   assign div0_in = op[1] & (OP_2 == '0);

   // One iteration of each algorithm; prod_q holds {acc, multiplier} or {rem, quo}.
   logic              is_mul;
   logic [DASize:0]   mul_sum;
   logic [W2-1:0]     mul_next, div_next, step_next;
   logic [DASize:0]   div_sh;
   logic [DASize-1:0] div_diff;
   logic              div_borrow;

   assign is_mul     = (op_q == MUL) || (op_q == MULHU);
   assign mul_sum    = {1'b0, prod_q[W2-1:DASize]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next   = {mul_sum, prod_q[DASize-1:1]};
   assign div_sh     = {prod_q[W2-1:DASize], prod_q[DASize-1]};
   assign div_borrow = div_sh < {1'b0, mcand_q};
   // Without a borrow the true difference is below the divisor, so the low word is exact.
   assign div_diff   = div_sh[DASize-1:0] - mcand_q;
   assign div_next   = {div_borrow ? div_sh[DASize-1:0] : div_diff,
                        prod_q[DASize-2:0], ~div_borrow};
   assign step_next  = is_mul ? mul_next : div_next;

   logic [W2-1:0]     prod_fix;
   logic [DASize-1:0] div_word, div_fix, calc_result;

   assign prod_fix    = neg_q ? -step_next : step_next;
   assign div_word    = (op_q == DIVU) ? step_next[DASize-1:0] : step_next[W2-1:DASize];
   assign div_fix     = neg_q ? -div_word : div_word;
   assign calc_result = !is_mul          ? div_fix :
                        (op_q == MULHU)  ? prod_fix[W2-1:DASize] :
                                           prod_fix[DASize-1:0];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      result_d = result_q;
      waddr_d  = waddr_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op_in;
               neg_d   = neg_in;
               waddr_d = Dest_ADDR;
               cnt_d   = '0;
               if (!op[1]) begin
                  prod_d  = {{DASize{1'b0}}, b_mag};
                  mcand_d = a_mag;
               end else begin
                  prod_d  = {{DASize{1'b0}}, a_mag};
                  mcand_d = b_mag;
               end
               if (div0_in) begin
                  state_d  = DONE;
                  result_d = (op_in == DIVU) ? DIV0_QUO[DASize-1:0] : OP_1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            prod_d = step_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DASize - 1)) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = calc_result;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         result_q <= '0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         result_q <= result_d;
         waddr_q  <= waddr_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign Write      = done;
   assign RESULT     = result_q;
   assign Write_ADDR = waddr_q;

endmodule
